miner_round_timer: RTL and testbench
====================================

// Module: miner_round_timer
// PURPOSE
//  Parametrised successor of the core timer. Counts hash rounds / timeout ticks for the miner core.
//  Adds run-time rollover and prescale values latched on start, periodic and one-shot modes,
//  pause, stop, a done pulse, busy status and an error flag.
//  Sits between the core control FSM and the SHA round datapath.
// PARAMETERS
//  CNT_WIDTH   7  width of count and rollover value (max rollover 2^CNT_WIDTH-1)
//  PRE_WIDTH   4  width of prescale value; tick every (prescale+1) running cycles
// PORTS
//  clk            in   1          system clock, rising edge
//  n_rst          in   1          asynchronous active-low reset
//  start          in   1          pulse: latch config, clear count, enter RUN
//  stop           in   1          pulse: abort, clear count, enter IDLE
//  pause          in   1          level: freeze prescaler and count while in RUN
//  oneshot        in   1          mode, sampled with start: 1=one-shot, 0=periodic
//  rollover_val   in   CNT_WIDTH  terminal count, sampled with start
//  prescale_val   in   PRE_WIDTH  prescale divider, sampled with start
//  count          out  CNT_WIDTH  current count
//  rollover_flag  out  1          high while count == latched rollover value
//  done           out  1          1-cycle pulse on each tick that makes count reach rollover
//  busy           out  1          high in RUN state
//  err            out  1          1-cycle pulse: start issued with rollover_val == 0
// BEHAVIOUR
//  Reset: state=IDLE; count=0, rollover_flag=0, done=0, busy=0, err=0.
//  Reset also clears the prescaler, rollover_lat, pre_lat and mode_lat. Reset mid-run aborts immediately.
//  FSM states:
//   - IDLE: count=0. start with rollover_val!=0 -> RUN. start with rollover_val==0 -> stay IDLE, err=1 next cycle.
//   - RUN: busy=1. Prescaler increments each non-paused cycle; at pre==pre_lat it wraps to 0 and asserts tick.
//   - DONE: one-shot finished. count holds at rollover_lat, rollover_flag=1, busy=0.
//  On start, latch rollover_lat, pre_lat and mode_lat, and clear count and prescaler.
//  Count on each tick:
//   - count==rollover_lat: count -> 1 (periodic only).
//   - otherwise: count -> count+1.
//  Count sequence is 0,1..R,1..R,... Count never returns to 0 while running.
//  done: registered, asserted the cycle count becomes R.
//  Periodic: stays in RUN. One-shot: RUN -> DONE on the tick reaching R.
//  DONE: start re-arms (-> RUN, count=0); stop -> IDLE (count=0).
//  stop in RUN -> IDLE next edge; count=0, prescaler=0, flags 0.
//  Latency: start at edge k gives busy=1 and count=0 after edge k.
//   - First increment at edge k+pre_lat+1.
//   - Period per count step = pre_lat+1 cycles (excluding paused cycles).
//  pause: no effect in IDLE/DONE. In RUN it freezes prescaler and count; no tick or done while paused.
//  Simultaneous events:
//   - stop+start: stop wins.
//   - start in RUN: restart with new config; any pending tick that cycle is discarded.
//   - pause+start: start takes effect, pause applies from the next cycle.
//  Config inputs are ignored except in the cycle start is accepted; mid-run changes have no effect.
//  rollover_flag is combinational from the count/rollover_lat compare, qualified by state != IDLE.
//  All other outputs are registered.
//  Max rollover (all ones) must wrap correctly with no overflow of the CNT_WIDTH compare.
// TESTING
//  1 Reset: n_rst=0 mid-RUN at count=5 -> all outputs 0 immediately (async), state IDLE.
//  2 Periodic, R=4, P=0: start -> count 0,1,2,3,4,1,2...
//    done pulses at each count=4; rollover_flag high exactly those cycles.
//  3 One-shot, R=3, P=2: start -> count steps every 3 cycles.
//    Reaches 3 at cycle 9; done=1 one cycle, busy->0, count holds 3; restart re-arms from 0.
//  4 Pause, R=10, P=0: pause for 5 cycles at count=4 -> count holds 4, no done.
//    Resumes 5 on the first unpaused edge.
//  5 start with rollover_val=0 -> err pulse 1 cycle, busy stays 0.
//    Then start+stop in the same cycle during RUN -> IDLE, count 0.
//  6 Max value, CNT_WIDTH=7, R=127, periodic: count wraps 127->1, done every 127 ticks.
//    Restart mid-run with R=2 -> count 0, then 1,2,1.

Source files
------------

// File: rtl/miner_round_timer.sv
// miner_round_timer
// Round / timeout counter for the miner core. Counts prescaled ticks up to a
// rollover value latched on start, in periodic or one-shot mode, with pause,
// stop, a done pulse on each terminal count, busy status and a config error pulse.

module miner_round_timer #(
    parameter int CNT_WIDTH = 7,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 oneshot,
    input  logic [CNT_WIDTH-1:0] rollover_val,
    input  logic [PRE_WIDTH-1:0] prescale_val,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 rollover_flag,
    output logic                 done,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic [CNT_WIDTH-1:0] rollover_lat, rollover_lat_nxt;
    logic [PRE_WIDTH-1:0] pre, pre_nxt;
    logic [PRE_WIDTH-1:0] pre_lat, pre_lat_nxt;
    logic                 mode_lat, mode_lat_nxt;
    logic                 done_nxt;
    logic                 err_nxt;
    logic                 busy_nxt;

    // State, counters, latched configuration and registered flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            pre          <= '0;
            rollover_lat <= '0;
            pre_lat      <= '0;
            mode_lat     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            pre          <= pre_nxt;
            rollover_lat <= rollover_lat_nxt;
            pre_lat      <= pre_lat_nxt;
            mode_lat     <= mode_lat_nxt;
            done         <= done_nxt;
            busy         <= busy_nxt;
            err          <= err_nxt;
        end
    end

    // Next-state logic: stop beats start, start beats any pending tick, and
    // ticks only happen in RUN on unpaused cycles when the prescaler wraps.
    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        pre_nxt          = pre;
        rollover_lat_nxt = rollover_lat;
        pre_lat_nxt      = pre_lat;
        mode_lat_nxt     = mode_lat;
        done_nxt         = 1'b0;
        err_nxt          = 1'b0;

        if (stop) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
            pre_nxt   = '0;
        end else if (start) begin
            count_nxt = '0;
            pre_nxt   = '0;
            if (rollover_val == '0) begin
                // A zero terminal count can never be reached: refuse to run.
                err_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end else begin
                rollover_lat_nxt = rollover_val;
                pre_lat_nxt      = prescale_val;
                mode_lat_nxt     = oneshot;
                state_nxt        = ST_RUN;
            end
        end else if (state == ST_RUN && !pause) begin
            if (pre == pre_lat) begin
                pre_nxt = '0;
                // Wrap to 1, not 0: count never returns to 0 while running.
                if (count == rollover_lat) begin
                    count_nxt = CNT_ONE;
                end else begin
                    count_nxt = count + CNT_ONE;
                end
                if (count_nxt == rollover_lat) begin
                    done_nxt = 1'b1;
                    if (mode_lat) begin
                        state_nxt = ST_DONE;
                    end
                end
            end else begin
                pre_nxt = pre + {{(PRE_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        busy_nxt = (state_nxt == ST_RUN);
    end

    // Terminal-count indication, suppressed while idle.
    assign rollover_flag = (state != ST_IDLE) && (count == rollover_lat);

endmodule

// File: tb/tb_miner_round_timer.sv
// tb_miner_round_timer
// Scoreboard bench: stimulus pushes expected outputs from a tick-counting
// reference model; a monitor pops and compares after every clock edge.

module tb_miner_round_timer;

    localparam int CW = 7;
    localparam int PW = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pause = 1'b0;
    logic          oneshot = 1'b0;
    logic [CW-1:0] rollover_val = '0;
    logic [PW-1:0] prescale_val = '0;
    logic [CW-1:0] count;
    logic          rollover_flag;
    logic          done;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [CW+3:0] exp_q[$];

    int m_phase  = PH_IDLE;
    int m_r      = 0;
    int m_p      = 0;
    bit m_one    = 1'b0;
    int m_active = 0;

    miner_round_timer #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .stop          (stop),
        .pause         (pause),
        .oneshot       (oneshot),
        .rollover_val  (rollover_val),
        .prescale_val  (prescale_val),
        .count         (count),
        .rollover_flag (rollover_flag),
        .done          (done),
        .busy          (busy),
        .err           (err)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Count implied by the number of unpaused running cycles since start.
    function automatic int model_count();
        int ticks;
        ticks = m_active / (m_p + 1);
        if (ticks == 0) return 0;
        if (m_one) return (ticks > m_r) ? m_r : ticks;
        return ((ticks - 1) % m_r) + 1;
    endfunction

    task automatic check_output(input string name, input logic [CW+3:0] act, input logic [CW+3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0t: got count=%0d flag=%b done=%b busy=%b err=%b, want count=%0d flag=%b done=%b busy=%b err=%b",
                     name, $time, act[CW+3:4], act[3], act[2], act[1], act[0],
                     exp[CW+3:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs and push the expected post-edge outputs.
    task automatic apply_stimulus(input logic s, input logic st, input logic pz, input logic om,
                                  input logic [CW-1:0] rv, input logic [PW-1:0] pv);
        bit exp_err;
        bit exp_done;
        int c;
        @(negedge clk);
        start = s; stop = st; pause = pz; oneshot = om;
        rollover_val = rv; prescale_val = pv;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (st) begin
            m_phase = PH_IDLE; m_active = 0;
        end else if (s) begin
            m_active = 0;
            if (rv == '0) begin
                exp_err = 1'b1; m_phase = PH_IDLE;
            end else begin
                m_r = int'(rv); m_p = int'(pv); m_one = om; m_phase = PH_RUN;
            end
        end else if (m_phase == PH_RUN && !pz) begin
            m_active++;
            if (m_active % (m_p + 1) == 0) begin
                c = model_count();
                if (c == m_r) begin
                    exp_done = 1'b1;
                    if (m_one) m_phase = PH_DONE;
                end
            end
        end
        c = (m_phase == PH_IDLE) ? 0 : model_count();
        exp_q.push_back({c[CW-1:0], (m_phase != PH_IDLE) && (c == m_r), exp_done,
                         m_phase == PH_RUN, exp_err});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset between edges; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; oneshot = 1'b0;
        rollover_val = '0; prescale_val = '0;
        #1;
        check_output("async_reset", {count, rollover_flag, done, busy, err}, '0);
        m_phase = PH_IDLE; m_active = 0; m_r = 0; m_p = 0; m_one = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        n_rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the oldest expectation after each edge.
    initial begin
        logic [CW+3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("cycle", {count, rollover_flag, done, busy, err}, e);
            end
        end
    end

    initial begin
        logic s, st, pz, om;
        logic [CW-1:0] rv;
        logic [PW-1:0] pv;
        int r;

        do_reset();

        // Periodic R=4 P=0.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd4, 4'd0);
        idle_cycles(12);

        // One-shot R=3 P=2, then re-arm and stop.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd3, 4'd2);
        idle_cycles(12);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 7'd3, 4'd2);
        idle_cycles(4);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Pause at count 4 with R=10, mid-run config changes ignored.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd10, 4'd0);
        idle_cycles(4);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 4'd3);
        idle_cycles(3);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);

        // Zero rollover error, then start+stop during RUN.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 4'd0);
        idle_cycles(2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd5, 4'd1);
        idle_cycles(3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'd6, 4'd0);
        idle_cycles(2);

        // Maximum rollover wraps 127 -> 1, then restart with R=2.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd127, 4'd0);
        idle_cycles(260);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'd2, 4'd0);
        idle_cycles(5);

        // Pause coincident with start, then reset mid-run at count 5.
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'd20, 4'd0);
        idle_cycles(5);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            s  = ($urandom_range(0, 29) == 0);
            st = ($urandom_range(0, 59) == 0);
            pz = ($urandom_range(0, 4) == 0);
            om = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 7)      rv = 7'($urandom_range(1, 12));
            else if (r < 8) rv = 7'd127;
            else if (r < 9) rv = 7'($urandom_range(1, 127));
            else            rv = (m_phase == PH_IDLE) ? 7'd0 : 7'd5;
            pv = 4'($urandom_range(0, 3));
            apply_stimulus(s, st, pz, om, rv, pv);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
